// File: rtl/debounce_multi.sv
// debounce_multi
//   Debounces CH independent mechanical inputs against one shared sample-rate
//   prescaler. Each channel produces a clean level, a one-clock press pulse
//   and a one-clock release pulse. All outputs are synchronous to clk.
//
//   Optional feature macro: DEBOUNCE_MULTI_LONG_PRESS_EN
//     When defined, each channel also gets a hold counter and a long_press
//     output that pulses once per press after LONG_CNT sample ticks held.
//
// Parameters
//   CH          number of independent channels (>=1)
//   SAMPLE_DIV  clk cycles per sample tick (>=1, 1 = tick every cycle)
//   STABLE_CNT  consecutive differing samples needed to accept a new level
//   ACTIVE_LOW  1: idle high / pressed low, 0: idle low / pressed high
//   LONG_CNT    ticks held before long_press fires (long-press build only)
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   btn         raw asynchronous button levels
//   btn_out     debounced level, same polarity as btn
//   press       one-clk pulse when a channel becomes pressed
//   rel         one-clk pulse when a channel becomes released
//   long_press  one-clk pulse after LONG_CNT ticks held (long-press build only)
module debounce_multi #(
  parameter int CH         = 4,
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 10,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int LONG_CNT   = 1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] btn_out,
  output logic [CH-1:0] press,
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
  output logic [CH-1:0] long_press,
`endif
  output logic [CH-1:0] rel
);

  localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(STABLE_CNT + 1);

  localparam logic [CH-1:0] IDLE     = ACTIVE_LOW ? {CH{1'b1}} : {CH{1'b0}};
  localparam logic          PRESSED  = !ACTIVE_LOW;
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  // Reject configurations the counters cannot represent.
  if (CH < 1 || SAMPLE_DIV < 1 || STABLE_CNT < 1 || LONG_CNT < 1) begin : g_bad_param
    $error("debounce_multi: CH, SAMPLE_DIV, STABLE_CNT and LONG_CNT must all be >= 1");
  end

  logic [CH-1:0]         sync1;
  logic [CH-1:0]         sync2;
  logic [PW-1:0]         pre;
  logic                  tick;
  logic [CH-1:0][CW-1:0] cnt;

  // Synchroniser stage: two flops per channel, idle level out of reset so a
  // released button never looks like activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Shared prescaler stage: one tick per SAMPLE_DIV clocks for all channels.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Qualification stage: a new level is accepted only after STABLE_CNT
  // consecutive ticks that all disagree with the current output. Any agreeing
  // sample restarts the count. Pulses are raised on the same edge that
  // updates btn_out, so they line up with the level change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_out <= IDLE;
      press   <= '0;
      rel     <= '0;
      cnt     <= '0;
    end else begin
      press <= '0;
      rel   <= '0;
      if (tick) begin
        for (int i = 0; i < CH; i++) begin
          if (sync2[i] == btn_out[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            btn_out[i] <= sync2[i];
            cnt[i]     <= '0;
            if (sync2[i] == PRESSED) begin
              press[i] <= 1'b1;
            end else begin
              rel[i] <= 1'b1;
            end
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
  localparam int              LW       = $clog2(LONG_CNT + 1);
  localparam logic [LW-1:0]   HOLD_MAX = LW'(LONG_CNT);

  logic [CH-1:0][LW-1:0] hold;

  // Hold stage: counts ticks while the debounced level is pressed and
  // saturates, so long_press fires only on the tick that reaches LONG_CNT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold       <= '0;
      long_press <= '0;
    end else begin
      long_press <= '0;
      for (int i = 0; i < CH; i++) begin
        if (btn_out[i] != PRESSED) begin
          hold[i] <= '0;
        end else if (tick && hold[i] != HOLD_MAX) begin
          hold[i] <= hold[i] + LW'(1);
          if (hold[i] == HOLD_MAX - LW'(1)) begin
            long_press[i] <= 1'b1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Testbench for debounce_multi (CH=2, SAMPLE_DIV=4, STABLE_CNT=3,
// ACTIVE_LOW=1, LONG_CNT=5). Compile with +define+DEBOUNCE_MULTI_LONG_PRESS_EN
// to include the long-press checks.
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] btn_out;
  logic [1:0] press;
  logic [1:0] rel;
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
  logic [1:0] long_press;
`endif

  int tests = 0;
  int fails = 0;

  debounce_multi #(
    .CH(2), .SAMPLE_DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1'b1), .LONG_CNT(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .btn_out(btn_out),
    .press(press),
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    .long_press(long_press),
`endif
    .rel(rel)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: the raw input seen two clocks late is sampled on every
  // 4th clock after reset; the output flips once the last three samples all
  // disagree with it. Long press: count ticks spent with the output pressed
  // and pulse when that count is exactly 5.
  logic [1:0] m_out, m_press, m_rel, m_long;
  logic [1:0] hist[$];
  logic       recent[2][3];
  int         nrec[2];
  int         m_hold[2];
  int         m_cyc;

  always @(posedge clk or negedge rst) begin
    logic [1:0] s;
    logic [1:0] old;
    if (!rst) begin
      m_out = 2'b11; m_press = 2'b00; m_rel = 2'b00; m_long = 2'b00;
      m_cyc = 0;
      hist.delete();
      hist.push_back(2'b11);
      hist.push_back(2'b11);
      for (int c = 0; c < 2; c++) begin
        nrec[c] = 0;
        m_hold[c] = 0;
      end
    end else begin
      m_press = 2'b00; m_rel = 2'b00; m_long = 2'b00;
      m_cyc++;
      hist.push_back(btn);
      s = hist[hist.size() - 3];
      if (hist.size() > 8) void'(hist.pop_front());
      old = m_out;
      for (int c = 0; c < 2; c++) begin
        if (old[c] != 1'b0) m_hold[c] = 0;
        else if (m_cyc % 4 == 0) begin
          m_hold[c]++;
          if (m_hold[c] == 5) m_long[c] = 1'b1;
        end
      end
      if (m_cyc % 4 == 0) begin
        for (int c = 0; c < 2; c++) begin
          recent[c][0] = recent[c][1];
          recent[c][1] = recent[c][2];
          recent[c][2] = s[c];
          if (nrec[c] < 3) nrec[c]++;
          if (nrec[c] == 3 && recent[c][0] != old[c] && recent[c][1] != old[c]
              && recent[c][2] != old[c]) begin
            m_out[c] = s[c];
            if (s[c] == 1'b0) m_press[c] = 1'b1;
            else m_rel[c] = 1'b1;
            nrec[c] = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({btn_out, press, rel} !== {m_out, m_press, m_rel}) begin
        fails++;
        $display("FAIL model t=%0t: out/press/rel got %b/%b/%b expected %b/%b/%b",
                 $time, btn_out, press, rel, m_out, m_press, m_rel);
      end
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
      tests++;
      if (long_press !== m_long) begin
        fails++;
        $display("FAIL model_long t=%0t: got %b expected %b", $time, long_press, m_long);
      end
`endif
    end
  end

  // Pulse counters.
  int pc[2], rc[2], lc[2];
  initial for (int i = 0; i < 2; i++) begin pc[i] = 0; rc[i] = 0; lc[i] = 0; end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (press[i] === 1'b1) pc[i]++;
      if (rel[i] === 1'b1) rc[i]++;
`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
      if (long_press[i] === 1'b1) lc[i]++;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 press[ch], 1 rel[ch], 2 btn_out[ch] pressed, 4 any press, 5 any rel
  task automatic wait_for(input string name, input int kind, input int ch,
                          input int limit, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (kind)
        0:       hit = (press[ch] === 1'b1);
        1:       hit = (rel[ch] === 1'b1);
        2:       hit = (btn_out[ch] === 1'b0);
        4:       hit = (press !== 2'b00);
        default: hit = (rel !== 2'b00);
      endcase
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  typedef struct {
    logic [1:0] btn;
    int         cycles;
    logic [1:0] exp_out;
  } vec_t;
  vec_t vt[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, hits, first;

    vt[0]  = '{2'b10, 16, 2'b10};
    vt[1]  = '{2'b11, 16, 2'b11};
    vt[2]  = '{2'b01, 16, 2'b01};
    vt[3]  = '{2'b00, 16, 2'b00};
    vt[4]  = '{2'b11, 16, 2'b11};
    vt[5]  = '{2'b10,  6, 2'b11};
    vt[6]  = '{2'b11, 16, 2'b11};
    vt[7]  = '{2'b00, 16, 2'b00};
    vt[8]  = '{2'b01,  6, 2'b00};
    vt[9]  = '{2'b00, 16, 2'b00};
    vt[10] = '{2'b11, 16, 2'b11};

    // Reset
    rst = 1'b0;
    btn = 2'b11;
    #100;
    check("rst_btn_out", 32'(btn_out), 32'h3);
    check("rst_press", 32'(press), 32'h0);
    check("rst_rel", 32'(rel), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    s0 = pc[0] + pc[1] + rc[0] + rc[1];
    repeat (1000) @(negedge clk);
    check("idle_no_pulse", 32'(pc[0] + pc[1] + rc[0] + rc[1]), 32'(s0));

    // Chatter shorter than a tick period on ch0
    s0 = pc[0];
    @(negedge clk);
    #5  btn[0] = 1'b0;
    #10 btn[0] = 1'b1;
    #30 btn[0] = 1'b0;
    #20 btn[0] = 1'b1;
    #10;
    repeat (20) @(negedge clk);
    check("chatter_out", 32'(btn_out[0]), 32'h1);
    check("chatter_press", 32'(pc[0]), 32'(s0));

    // Clean press and release on ch0
    s0 = pc[0];
    @(negedge clk);
    btn[0] = 1'b0;
    wait_for("press_fall", 2, 0, 40, n);
    tests++;
    if (n < 11 || n > 14) begin
      fails++;
      $display("FAIL press_latency: got %0d cycles required 11..14", n);
    end
    check("press_aligned", 32'(press), 32'h1);
    @(negedge clk);
    check("press_one_cycle", 32'(press[0]), 32'h0);
    check("press_ch1_idle", 32'(btn_out[1]), 32'h1);
    repeat (8) @(negedge clk);
    btn[0] = 1'b1;
    wait_for("rel_ch0", 1, 0, 40, n);
    check("rel_value", 32'(rel), 32'h1);
    @(negedge clk);
    check("rel_one_cycle", 32'(rel[0]), 32'h0);
    check("press_count", 32'(pc[0] - s0), 32'h1);
    check("clean_ch1_out", 32'(btn_out[1]), 32'h1);

    // Simultaneous channels
    @(negedge clk);
    btn = 2'b00;
    wait_for("sim_press", 4, 0, 40, n);
    check("sim_press_both", 32'(press), 32'h3);
    repeat (10) @(negedge clk);
    btn = 2'b10;
    wait_for("sim_rel", 5, 0, 40, n);
    check("sim_rel_ch1", 32'(rel), 32'h2);
    check("sim_out", 32'(btn_out), 32'h2);
    btn = 2'b11;
    repeat (20) @(negedge clk);

    // Reset during qualification, button held through it
    @(negedge clk);
    btn[0] = 1'b0;
    repeat (8) @(negedge clk);
    #5 rst = 1'b0;
    #1;
    check("midrst_out", 32'(btn_out), 32'h3);
    check("midrst_press", 32'(press), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_for("midrst_repress", 0, 0, 40, n);
    check("midrst_press_delay", 32'(n), 32'd12);
    repeat (4) @(negedge clk);
    btn = 2'b11;
    repeat (20) @(negedge clk);

    // Vector table
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      btn = vt[v].btn;
      repeat (vt[v].cycles - 1) @(negedge clk);
      check($sformatf("vec%0d_out", v), 32'(btn_out), 32'(vt[v].exp_out));
    end

    // Random stimulus, checked by the model every cycle
    for (int r = 0; r < 150; r++) begin
      @(negedge clk);
      btn = 2'($urandom);
      repeat ($urandom_range(1, 30) - 1) @(negedge clk);
    end
    @(negedge clk);
    btn = 2'b11;
    repeat (20) @(negedge clk);
    check("rand_settle", 32'(btn_out), 32'h3);

`ifdef DEBOUNCE_MULTI_LONG_PRESS_EN
    // Long hold: one long_press exactly 5 ticks after press
    @(negedge clk);
    btn = 2'b10;
    wait_for("long_press0", 0, 0, 40, n);
    hits = 0;
    first = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (long_press[0] === 1'b1) begin
        hits++;
        if (first == 0) first = k;
      end
    end
    check("long_once", 32'(hits), 32'd1);
    check("long_delay", 32'(first), 32'd20);
    btn = 2'b11;
    wait_for("long_rel", 1, 0, 40, n);
    repeat (4) @(negedge clk);
    // Short hold: released before 5 ticks
    s0 = lc[0];
    btn = 2'b10;
    wait_for("short_press", 0, 0, 40, n);
    repeat (4) @(negedge clk);
    btn = 2'b11;
    wait_for("short_rel", 1, 0, 40, n);
    repeat (30) @(negedge clk);
    check("long_short_none", 32'(lc[0]), 32'(s0));
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
